mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_alu.sv | 65 ++++++
 rtl/mdu_ctrl.sv | 103 ++++++++++
 tb/tb_mdu_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit controller.
// Define MDU_MADD_EN at build time to enable the MADD/MSUB accumulate operations.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MSUB  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;
    localparam int CNT_W               = 16;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    // Operations that occupy the unit for several cycles and commit through the pending register.
    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
            OP_MADD, OP_MSUB:                   return MADD_EN;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath producing the next {HI,LO} pair.
// MADD/MSUB are only computed when MDU_MADD_EN is defined; otherwise they pass HI/LO through.
module mdu_alu
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               b_zero;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without trapping.
    assign b_zero = (b == 32'd0);
    assign a_mag  = a[31] ? -a : a;
    assign b_mag  = b[31] ? -b : b;
    assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
    assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;
    assign q_u    = b_zero ? 32'd0 : a / b;
    assign r_u    = b_zero ? 32'd0 : a % b;

    always_comb begin
        result = {hi, lo};
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (!b_zero) begin
                    result = {(a[31] ? -r_mag : r_mag), ((a[31] ^ b[31]) ? -q_mag : q_mag)};
                end
            end
            OP_DIVU: begin
                if (!b_zero) begin
                    result = {r_u, q_u};
                end
            end
            OP_MADD: begin
                if (MADD_EN) begin
                    result = {hi, lo} + prod_s;
                end
            end
            OP_MSUB: begin
                if (MADD_EN) begin
                    result = {hi, lo} - prod_s;
                end
            end
            default: result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer: holds HI/LO, runs the fixed-latency busy window and raises stall.
// Define MDU_MADD_EN to accept MADD/MSUB; without it those codes behave as NONE.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_uses_mdu,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e         state;
    mdu_state_e         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [63:0]        pending;
    logic [63:0]        pending_next;
    logic [31:0]        hi_q;
    logic [31:0]        hi_next;
    logic [31:0]        lo_q;
    logic [31:0]        lo_next;
    logic [63:0]        alu_result;
    logic               long_op;
    logic [CNT_W-1:0]   op_cycles;

    mdu_alu u_alu (
        .op     (op),
        .a      (A),
        .b      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (alu_result)
    );

    assign long_op   = is_long_op(op);
    assign op_cycles = (op == OP_DIV || op == OP_DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            hi_q    <= hi_next;
            lo_q    <= lo_next;
        end
    end

    // The result is captured at start; the busy window only delays when HI/LO see it.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        hi_next      = hi_q;
        lo_next      = lo_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (long_op) begin
                        pending_next = alu_result;
                        cnt_next     = op_cycles;
                        state_next   = ST_BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_next = A;
                    end else if (op == OP_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            ST_BUSY: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    hi_next    = pending[63:32];
                    lo_next    = pending[31:0];
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy  = (state == ST_BUSY);
    assign stall = d_uses_mdu & (busy | (start & long_op));
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO, busy and stall values.
// Honours MDU_MADD_EN so the accumulate checks match the build of the design.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        d_uses_mdu;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .A          (A),
        .B          (B),
        .d_uses_mdu (d_uses_mdu),
        .busy       (busy),
        .stall      (stall),
        .HI         (HI),
        .LO         (LO)
    );

    // Upstream must never issue while the unit is busy.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(busy && start)) else $error("[TB] start issued while busy");
        end
    end

    // Issues one start cycle and returns at the following negedge.
    task automatic drive_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = OP_NONE; A = '0; B = '0; d_uses_mdu = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("[TB] FAIL reset_hi: got %h want 0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("[TB] FAIL reset_lo: got %h want 0", LO); end
        d_uses_mdu = 1'b1; start = 1'b1; op = OP_MULT;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL reset_stall_comb: got %b want 1", stall); end
        start = 1'b0; op = OP_NONE;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall_idle: got %b want 0", stall); end
        @(negedge clk);
        reset = 1'b0; d_uses_mdu = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        drive_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        total++; if (n != 5) begin bad++; $display("[TB] FAIL mult_busy: got %0d want 5", n); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL mult_hi: got %h want ffffffff", HI); end
        total++; if (LO !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL mult_lo: got %h want fffffffe", LO); end
        drive_op(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
        count_busy(n);
        total++; if (n != 5) begin bad++; $display("[TB] FAIL multu_busy: got %0d want 5", n); end
        total++; if (HI !== 32'd2) begin bad++; $display("[TB] FAIL multu_hi: got %h want 2", HI); end
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL multu_lo: got %h want fffffffd", LO); end
        drive_op(OP_MULT, 32'h8000_0000, 32'd3);
        count_busy(n);
        total++; if (HI !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL mult_neg_hi: got %h want fffffffe", HI); end
        total++; if (LO !== 32'h8000_0000) begin bad++; $display("[TB] FAIL mult_neg_lo: got %h want 80000000", LO); end
    endtask

    task automatic test_div();
        int n;
        drive_op(OP_DIVU, 32'd7, 32'd2);
        count_busy(n);
        total++; if (n != 10) begin bad++; $display("[TB] FAIL divu_busy: got %0d want 10", n); end
        total++; if (LO !== 32'd3) begin bad++; $display("[TB] FAIL divu_lo: got %h want 3", LO); end
        total++; if (HI !== 32'd1) begin bad++; $display("[TB] FAIL divu_hi: got %h want 1", HI); end
        drive_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL div_neg_lo: got %h want fffffffd", LO); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL div_neg_hi: got %h want ffffffff", HI); end
        drive_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        count_busy(n);
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL div_negb_lo: got %h want fffffffd", LO); end
        total++; if (HI !== 32'd1) begin bad++; $display("[TB] FAIL div_negb_hi: got %h want 1", HI); end
        drive_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        total++; if (LO !== 32'h8000_0000) begin bad++; $display("[TB] FAIL div_ovf_lo: got %h want 80000000", LO); end
        total++; if (HI !== 32'd0) begin bad++; $display("[TB] FAIL div_ovf_hi: got %h want 0", HI); end
    endtask

    task automatic test_div_zero();
        int n;
        drive_op(OP_MTHI, 32'h1234_5678, 32'd0);
        total++; if (HI !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mthi: got %h want 12345678", HI); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy: got %b want 0", busy); end
        drive_op(OP_MTLO, 32'h1234_5678, 32'd0);
        total++; if (LO !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mtlo: got %h want 12345678", LO); end
        drive_op(OP_DIV, 32'd5, 32'd0);
        count_busy(n);
        total++; if (n != 10) begin bad++; $display("[TB] FAIL divz_busy: got %0d want 10", n); end
        total++; if (HI !== 32'h1234_5678) begin bad++; $display("[TB] FAIL divz_hi: got %h want 12345678", HI); end
        total++; if (LO !== 32'h1234_5678) begin bad++; $display("[TB] FAIL divz_lo: got %h want 12345678", LO); end
    endtask

    task automatic test_stall();
        int n;
        int stall_ones;
        d_uses_mdu = 1'b1;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd4;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL stall_start: got %b want 1", stall); end
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (stall !== 1'b1 || busy !== 1'b1) begin
                bad++; $display("[TB] FAIL stall_busy_%0d: got stall=%b busy=%b want 1/1", i, stall, busy);
            end
            @(negedge clk);
        end
        #1;
        total++; if (stall !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_after: got stall=%b busy=%b want 0/0", stall, busy);
        end
        total++; if (LO !== 32'd12) begin bad++; $display("[TB] FAIL stall_lo: got %h want c", LO); end
        d_uses_mdu = 1'b0;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; A = 32'd5; B = 32'd5;
        #1;
        stall_ones = int'(stall);
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            #1;
            stall_ones += int'(stall);
            n++;
            @(negedge clk);
        end
        total++; if (stall_ones != 0) begin bad++; $display("[TB] FAIL stall_nouse: got %0d stall cycles want 0", stall_ones); end
        total++; if (n != 5) begin bad++; $display("[TB] FAIL stall_nouse_busy: got %0d want 5", n); end
    endtask

    task automatic test_reset_busy();
        drive_op(OP_MTHI, 32'hAAAA_0000, 32'd0);
        drive_op(OP_MTLO, 32'h0000_5555, 32'd0);
        drive_op(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rb_busy3: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rb_busy: got %b want 0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("[TB] FAIL rb_hi: got %h want 0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("[TB] FAIL rb_lo: got %h want 0", LO); end
        repeat (12) @(negedge clk);
        total++; if (HI !== 32'd0 || LO !== 32'd0) begin
            bad++; $display("[TB] FAIL rb_discard: got %h_%h want 0_0", HI, LO);
        end
        drive_op(OP_MTLO, 32'd9, 32'd0);
        total++; if (LO !== 32'd9) begin bad++; $display("[TB] FAIL rb_mtlo: got %h want 9", LO); end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = OP_MTLO; A = 32'h55;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = OP_MULT; A = 32'd5; B = 32'd5;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; op = OP_NONE;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rp_busy: got %b want 0", busy); end
        total++; if (LO !== 32'd0) begin bad++; $display("[TB] FAIL rp_lo: got %h want 0", LO); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rp_busy_late: got %b want 0", busy); end
    endtask

    task automatic test_none();
        drive_op(OP_MTLO, 32'h77, 32'd0);
        drive_op(OP_NONE, 32'h99, 32'h3);
        total++; if (busy !== 1'b0 || LO !== 32'h77 || HI !== 32'd0) begin
            bad++; $display("[TB] FAIL none_op: got busy=%b hi=%h lo=%h want 0/0/77", busy, HI, LO);
        end
        @(negedge clk);
        start = 1'b0; op = OP_MTLO; A = 32'h11;
        @(negedge clk);
        op = OP_NONE;
        total++; if (LO !== 32'h77) begin bad++; $display("[TB] FAIL no_start: got %h want 77", LO); end
    endtask

    task automatic test_madd();
        int n;
        drive_op(OP_MTHI, 32'd0, 32'd0);
        drive_op(OP_MTLO, 32'd10, 32'd0);
        drive_op(OP_MADD, 32'd3, 32'd4);
        count_busy(n);
`ifdef MDU_MADD_EN
        total++; if (n != 5) begin bad++; $display("[TB] FAIL madd_busy: got %0d want 5", n); end
        total++; if (LO !== 32'd22 || HI !== 32'd0) begin bad++; $display("[TB] FAIL madd: got %h_%h want 0_16", HI, LO); end
        drive_op(OP_MSUB, 32'd2, 32'd20);
        count_busy(n);
        total++; if (LO !== 32'hFFFF_FFEE || HI !== 32'hFFFF_FFFF) begin
            bad++; $display("[TB] FAIL msub: got %h_%h want ffffffff_ffffffee", HI, LO);
        end
`else
        total++; if (n != 0) begin bad++; $display("[TB] FAIL madd_off_busy: got %0d want 0", n); end
        total++; if (LO !== 32'd10) begin bad++; $display("[TB] FAIL madd_off_lo: got %h want a", LO); end
        drive_op(OP_MSUB, 32'd2, 32'd20);
        count_busy(n);
        total++; if (n != 0 || LO !== 32'd10 || HI !== 32'd0) begin
            bad++; $display("[TB] FAIL msub_off: got busy=%0d hi=%h lo=%h want 0/0/a", n, HI, LO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_busy();
        test_reset_priority();
        test_none();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
